// File: rtl/i2c_write_master.sv
`default_nettype none
// ============================================================================
// i2c_write_master: serialises one {SubAddrL, data} command as a 3-byte I2C
// write (device address, sub-address, data) and pulses NewCom when done.
// Optional NACK retry/AckErr logic: define I2C_ACK_CHECK_EN.
// Revision: 1.0
// ============================================================================
module i2c_write_master #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         DIV       = 4,
    parameter int         MAX_RETRY = 3
) (
    input  logic       I2C_clk,
    input  logic       reset,
    input  logic       Write,
    input  logic [7:0] SubAddrL,
    input  logic [7:0] data,
    input  logic       SDA_in,
    output logic       SCL,
    output logic       SDA_oe,
    output logic       NewCom,
    output logic       Busy,
    output logic       AckErr
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_BIT     = 3'd2,
        S_ACK     = 3'd3,
        S_STOP    = 3'd4,
`ifdef I2C_ACK_CHECK_EN
        S_RESTART = 3'd6,
`endif
        S_DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [4:0]    bit_q, bit_d;
    logic [4:0]    dbit_q, dbit_d;
    logic [23:0]   frame_q, frame_d;
    logic          phase_end;
    logic          slot_end;
    logic          scl_bit;

`ifdef I2C_ACK_CHECK_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
    logic          nack_q, nack_d;
    logic          ackerr_q, ackerr_d;
`else
    logic          unused_ok;
    assign unused_ok = ^{SDA_in, MAX_RETRY[0]};
`endif

    assign phase_end = (cnt_q == CNT_LAST);
    assign slot_end  = phase_end && (phase_q == 2'd3);
    assign scl_bit   = (phase_q == 2'd1) || (phase_q == 2'd2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        dbit_d  = dbit_q;
        frame_d = frame_q;
        SCL     = 1'b1;
        SDA_oe  = 1'b0;
        NewCom  = 1'b0;
        Busy    = 1'b1;
`ifdef I2C_ACK_CHECK_EN
        retry_d  = retry_q;
        nack_d   = nack_q;
        ackerr_d = ackerr_q;
`endif

        // Quarter-bit timebase runs only while a slot is being clocked out.
        if ((state_q == S_START) || (state_q == S_BIT) ||
            (state_q == S_ACK)   || (state_q == S_STOP)) begin
            if (phase_end) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                Busy    = 1'b0;
                cnt_d   = '0;
                phase_d = 2'd0;
                bit_d   = 5'd0;
                dbit_d  = 5'd0;
                if (Write) begin
                    frame_d = {DEV_ADDR, 1'b0, SubAddrL, data};
                    state_d = S_START;
`ifdef I2C_ACK_CHECK_EN
                    retry_d  = '0;
                    nack_d   = 1'b0;
                    ackerr_d = 1'b0;
`endif
                end
            end

            S_START: begin
                SDA_oe = phase_q[1];
`ifdef I2C_ACK_CHECK_EN
                nack_d = 1'b0;
`endif
                if (slot_end) begin
                    state_d = S_BIT;
                end
            end

            S_BIT: begin
                SCL    = scl_bit;
                SDA_oe = ~frame_q[5'd23 - dbit_q];
                if (slot_end) begin
                    bit_d  = bit_q + 5'd1;
                    dbit_d = dbit_q + 5'd1;
                    if ((bit_q == 5'd7) || (bit_q == 5'd16) || (bit_q == 5'd25)) begin
                        state_d = S_ACK;
                    end
                end
            end

            S_ACK: begin
                SCL = scl_bit;
`ifdef I2C_ACK_CHECK_EN
                if ((phase_q == 2'd1) && phase_end) begin
                    nack_d = SDA_in;
                end
`endif
                if (slot_end) begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd26) begin
                        state_d = S_STOP;
`ifdef I2C_ACK_CHECK_EN
                    end else if (nack_q) begin
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_BIT;
                    end
                end
            end

            S_STOP: begin
                SCL    = (phase_q != 2'd0);
                SDA_oe = (phase_q < 2'd2);
                if (slot_end) begin
`ifdef I2C_ACK_CHECK_EN
                    if (nack_q) begin
                        if (retry_q == RW'(MAX_RETRY)) begin
                            ackerr_d = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            retry_d  = retry_q + 1'b1;
                            state_d  = S_RESTART;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end

`ifdef I2C_ACK_CHECK_EN
            S_RESTART: begin
                cnt_d   = '0;
                phase_d = 2'd0;
                bit_d   = 5'd0;
                dbit_d  = 5'd0;
                state_d = S_START;
            end
`endif

            S_DONE: begin
                NewCom  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I2C_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= 2'd0;
            bit_q   <= 5'd0;
            dbit_q  <= 5'd0;
            frame_q <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            dbit_q  <= dbit_d;
            frame_q <= frame_d;
        end
    end

`ifdef I2C_ACK_CHECK_EN
    always_ff @(posedge I2C_clk or posedge reset) begin
        if (reset) begin
            retry_q  <= '0;
            nack_q   <= 1'b0;
            ackerr_q <= 1'b0;
        end else begin
            retry_q  <= retry_d;
            nack_q   <= nack_d;
            ackerr_q <= ackerr_d;
        end
    end

    assign AckErr = ackerr_q;
`else
    assign AckErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Downstream consumer of the command sequencer: takes one {SubAddrL, data} command per Write request and serialises it as a 3-byte I2C write: device address, sub-address, data.
- Pulses NewCom when the frame completes, which advances the sequencer's command counter to the next entry.
- Drives the codec configuration bus: SCL push-pull, SDA open-drain through an external tristate.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit slave address; R/W bit is always 0 (write).
- DIV, 4, I2C_clk cycles per quarter-bit phase; SCL period = 4*DIV cycles; must be >= 1.
- MAX_RETRY, 3, NACK retries per command; used only when I2C_ACK_CHECK_EN is defined.

Ports:
- I2C_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Write  in  1  command request (level); sampled only in IDLE.
- SubAddrL  in  8  sub-address byte; latched on acceptance.
- data  in  8  data byte; latched on acceptance.
- SDA_in  in  1  sampled SDA line, for ACK.
- SCL  out  1  I2C clock.
- SDA_oe  out  1  1 = pull SDA low, 0 = release (line high).
- NewCom  out  1  one-cycle completion pulse.
- Busy  out  1  high from acceptance until the NewCom cycle, inclusive.
- AckErr  out  1  sticky NACK-failure flag; 0 unless the optional feature is enabled.

Behaviour:
- Reset (asynchronous, any state): state IDLE, SCL=1, SDA_oe=0, NewCom=0, Busy=0, AckErr=0, all counters 0. Reset mid-frame abandons the frame with no STOP; the bus simply floats high.
- IDLE: SCL=1, SDA_oe=0. If Write=1 on a rising edge:
  - latch shift word {DEV_ADDR,1'b0}, SubAddrL, data;
  - set Busy=1; go to START.
- Write while Busy is ignored. Input changes after acceptance have no effect.
- Phase counter: counts 0..DIV-1 per phase, 4 phases (P0..P3) per bit slot.
- START slot: P0-P1 SDA released, SCL=1; P2-P3 SDA_oe=1, SCL=1; then SCL=0 entering the first bit.
- BIT slot (24 data bits, MSB first):
  - P0: SCL=0, SDA_oe=~bit.
  - P1-P2: SCL=1.
  - P3: SCL=0.
  - SDA only changes in P0.
- ACK slot (after every 8 bits): SDA_oe=0 for the whole slot, same SCL pattern as BIT. SDA_in is sampled on the last cycle of P1; 0 = ACK.
- STOP slot:
  - P0: SCL=0, SDA_oe=1.
  - P1: SCL=1, SDA_oe=1.
  - P2-P3: SCL=1, SDA_oe=0.
- DONE: one cycle; NewCom=1 and Busy=1; next state IDLE.
- If Write is still high, the next command is accepted on the first IDLE cycle. Back-to-back frames are therefore separated by exactly 1 IDLE cycle.
- Frame length: 1 START + 27 bit/ACK + 1 STOP = 29 slots = 116*DIV cycles. NewCom is asserted in cycle 116*DIV+1 after the acceptance edge (464+1 for DIV=4).
- Bit counter 0..26. Byte boundaries are at counts 8, 17 and 26 (ACK slots).
- State set: IDLE, START, BIT, ACK, STOP, DONE, plus RESTART when the optional feature is enabled.

Optional Feature:
- Macro: I2C_ACK_CHECK_EN.
- Defined:
  - A sampled NACK (SDA_in=1) in any ACK slot aborts the remaining bits and goes straight to STOP, then RESTART.
  - RESTART: one IDLE-level cycle (SCL=1, SDA released), then a new START with the same latched bytes. The retry counter increments.
  - After MAX_RETRY failed retries (MAX_RETRY+1 attempts in total): STOP, then DONE with NewCom pulsed, and AckErr set to 1.
  - AckErr clears only on reset or on acceptance of the next Write.
  - A successful frame behaves exactly as in the base timing.
- Undefined: the ACK slot is clocked but SDA_in is ignored; AckErr is tied to 0; there is no retry logic or counter.

Test Plan:
- Reset with Write=0 -> SCL=1, SDA_oe=0, NewCom=0, Busy=0, AckErr=0; holds for 100 cycles.
- DIV=4, SubAddrL=8'h0C, data=8'h1F, Write pulsed 1 cycle, slave ACKs all bytes -> bus decodes bytes 8'h34, 8'h0C, 8'h1F with START/STOP. NewCom is a single-cycle pulse 465 cycles after acceptance; Busy falls the following cycle.
- Write held high for 3 commands, upstream changing bytes on NewCom -> 3 frames with exactly 1 idle cycle between them, and 3 NewCom pulses spaced 466 cycles apart.
- Change SubAddrL and data mid-frame, and assert Write while Busy -> transmitted bytes equal the latched values; no extra frame is started.
- Async reset asserted during bit 10 -> SCL=1 and SDA_oe=0 immediately (no clock edge needed); no NewCom; a new Write after release starts a fresh frame.
- With I2C_ACK_CHECK_EN: slave NACKs the data byte always -> 4 attempts, then NewCom pulse and AckErr=1. Next Write with ACK -> AckErr=0, normal 465-cycle completion.
